aes_dec_word_loader: RTL and testbench
======================================

Name: aes_dec_word_loader

Overview:
- Upstream front end for the AES decrypt core.
- Accepts 32-bit words over a valid/ready stream and assembles an Nk-word key and a 128-bit ciphertext block. It holds both stable on the core's dataIn/keyIn inputs.
- Waits a fixed number of cycles for the core's pipelined result, captures the plaintext, and presents it on a valid/ready output.
- Guarantees the core's inputs never change while a block is in flight.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8); must match the core's Nk.
- LATENCY, 12, cycles from the core's inputs being stable to its output being valid; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inValid  in  1  input word valid.
- inReady  out  1  input word accepted when inValid && inReady.
- inWord  in  32  key or ciphertext word.
- inIsKey  in  1  1 = inWord is a key word; 0 = ciphertext word.
- keyOut  out  NK*32  to the core's keyIn.
- cipherOut  out  128  to the core's dataIn.
- plainIn  in  128  from the core's dataOut.
- plainOut  out  128  registered plaintext.
- plainValid  out  1  plaintext valid.
- plainReady  in  1  consumer accepts plainOut when plainValid && plainReady.

Behaviour:
- Reset (async assert, sync release):
  - keyOut, cipherOut, plainOut = 0; plainValid = 0.
  - state = LOAD; keyCnt = 0; dataCnt = 0; keyValid = 0.
- Word order is big-endian:
  - data word k (k = 0..3) goes to cipherOut[127-32k -: 32];
  - key word k goes to keyOut[NK*32-1-32k -: 32].
- FSM states: LOAD, WAIT, HOLD.
- LOAD, handshake:
  - inReady = (inIsKey && dataCnt == 0) || (!inIsKey && keyValid).
  - inReady is combinational and 0 in WAIT and HOLD.
  - inValid may wait on inReady; inReady may depend on inIsKey. The producer must hold inWord and inIsKey stable until accepted.
- LOAD, key word accepted:
  - Written to slot keyCnt.
  - keyCnt == 0 clears keyValid (a new key has started).
  - keyCnt == NK-1 sets keyValid and wraps keyCnt to 0; otherwise keyCnt increments.
- LOAD, data word accepted:
  - Written to slot dataCnt.
  - dataCnt == 3: dataCnt returns to 0, cnt loads LATENCY-1, state moves to WAIT.
- Partial-load rules:
  - Key words are refused while a data block is partially loaded (dataCnt != 0).
  - Data words are refused while the key is incomplete.
  - A partial key rewrite leaves keyValid = 0 until all NK new words are written; keyOut shows a mixed key in the meantime.
- WAIT:
  - cnt decrements each cycle.
  - When cnt == 0: plainOut <= plainIn, plainValid <= 1, state moves to HOLD.
  - Timing: last data word accepted at edge N gives cipherOut updated at N and plainValid high after edge N+LATENCY.
- HOLD:
  - plainOut and plainValid hold until plainReady.
  - On accept: plainValid <= 0, state moves to LOAD.
  - The next input word can be accepted in the cycle after the accept; no combinational ready path from plainReady to inReady.
- The key persists across blocks. keyValid stays 1, so subsequent blocks need only 4 data words.
- cipherOut and keyOut change only on accepted words in LOAD, so they are stable through WAIT and HOLD.
- Reset mid-operation: any state returns to LOAD, the key is lost, and plainValid drops immediately (async).
- plainReady while plainValid = 0 is ignored; inValid in WAIT or HOLD is ignored.

Decomposition:
- Shared package aes_pkg:
  - state enum (LOAD, WAIT, HOLD);
  - BLOCK_W = 128, WORD_W = 32;
  - function for slot index to bit offset.
- Single module, no sub-modules. The LATENCY counter is inline, width $clog2(LATENCY+1).

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f, then ciphertext words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with the real core or a model of latency LATENCY -> plainOut = 00112233445566778899aabbccddeeff. plainValid rises exactly LATENCY edges after the 4th data word is accepted.
- Data word offered before any key word -> inReady = 0 until the 4th key word is accepted; the word is then accepted next cycle.
- Key word offered after 2 data words -> inReady = 0; the remaining 2 data words are still accepted; the key is accepted only after the block completes HOLD.
- Hold plainReady = 0 for 20 cycles -> plainValid and plainOut stable; inReady = 0; cipherOut and keyOut unchanged. Then release plainReady -> back to LOAD.
- Second block with the same key (4 data words only) -> correct plaintext; keyOut unchanged throughout.
- Assert rst_n = 0 during WAIT -> plainValid = 0, all outputs 0. After release, data words are refused until a full key is reloaded.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES decrypt front-end loader.
// Word slots are big-endian: slot 0 lands in the most significant word.
package aes_pkg;

   localparam int BLOCK_W = 128;
   localparam int WORD_W  = 32;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Bit offset of the LSB of word slot 'slot' inside an 'nwords'-word vector.
   function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned nwords);
      return (nwords - 1 - slot) * WORD_W;
   endfunction

endpackage

// File: rtl/aes_dec_word_loader.sv
// Collects key and ciphertext words for the AES decrypt core, holds them stable while the
// core's fixed-latency pipeline runs, then captures and presents the plaintext.
module aes_dec_word_loader
   import aes_pkg::*;
#(
   parameter int NK      = 4,
   parameter int LATENCY = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [WORD_W-1:0]    inWord,
   input  logic                 inIsKey,
   output logic [NK*WORD_W-1:0] keyOut,
   output logic [BLOCK_W-1:0]   cipherOut,
   input  logic [BLOCK_W-1:0]   plainIn,
   output logic [BLOCK_W-1:0]   plainOut,
   output logic                 plainValid,
   input  logic                 plainReady
);

   localparam int KCW = (NK > 1) ? $clog2(NK) : 1;
   localparam int CW  = $clog2(LATENCY + 1);

   state_e                r_state;
   logic [KCW-1:0]        r_key_cnt;
   logic [1:0]            r_data_cnt;
   logic                  r_key_valid;
   logic [CW-1:0]         r_cnt;
   logic [NK*WORD_W-1:0]  r_key;
   logic [BLOCK_W-1:0]    r_cipher;
   logic [BLOCK_W-1:0]    r_plain;
   logic                  r_plain_valid;

   logic                  w_ready;
   logic                  w_accept;

   // Key words only between blocks; data words only once a full key is present.
   assign w_ready  = (r_state == ST_LOAD) &&
                     ((inIsKey && (r_data_cnt == 2'd0)) || (!inIsKey && r_key_valid));
   assign w_accept = inValid && w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_LOAD;
         r_key_cnt     <= '0;
         r_data_cnt    <= '0;
         r_key_valid   <= 1'b0;
         r_cnt         <= '0;
         r_key         <= '0;
         r_cipher      <= '0;
         r_plain       <= '0;
         r_plain_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_accept) begin
                  if (inIsKey) begin
                     r_key[slot_lsb(32'(r_key_cnt), NK) +: WORD_W] <= inWord;
                     if (r_key_cnt == '0)
                        r_key_valid <= 1'b0;
                     if (r_key_cnt == KCW'(NK - 1)) begin
                        r_key_valid <= 1'b1;
                        r_key_cnt   <= '0;
                     end else begin
                        r_key_cnt <= r_key_cnt + 1'b1;
                     end
                  end else begin
                     r_cipher[slot_lsb(32'(r_data_cnt), 4) +: WORD_W] <= inWord;
                     if (r_data_cnt == 2'd3) begin
                        r_data_cnt <= '0;
                        r_cnt      <= CW'(LATENCY - 1);
                        r_state    <= ST_WAIT;
                     end else begin
                        r_data_cnt <= r_data_cnt + 1'b1;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_plain       <= plainIn;
                  r_plain_valid <= 1'b1;
                  r_state       <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (plainReady) begin
                  r_plain_valid <= 1'b0;
                  r_state       <= ST_LOAD;
               end
            end
            default: r_state <= ST_LOAD;
         endcase
      end
   end

   assign inReady    = w_ready;
   assign keyOut     = r_key;
   assign cipherOut  = r_cipher;
   assign plainOut   = r_plain;
   assign plainValid = r_plain_valid;

endmodule

// File: tb/tb_aes_dec_word_loader.sv
// Directed bench for aes_dec_word_loader with a fixed-latency stand-in for the AES core.
// The stand-in returns the real FIPS-197 plaintext for the known vector and cipher^key otherwise.
module tb_aes_dec_word_loader;

   localparam int LAT = 12;
   localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C2  = 128'h11111111111111111111111111111111;
   localparam logic [127:0] PT2 = 128'h111013121514171619181b1a1d1c1f1e;

   logic         clk, rst_n;
   logic         inValid, inReady, inIsKey, plainValid, plainReady;
   logic [31:0]  inWord;
   logic [127:0] keyOut, cipherOut, plainIn, plainOut;

   int pass_cnt = 0;
   int total_cnt = 0;

   aes_dec_word_loader #(.NK(4), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .inValid(inValid), .inReady(inReady), .inWord(inWord), .inIsKey(inIsKey),
      .keyOut(keyOut), .cipherOut(cipherOut), .plainIn(plainIn),
      .plainOut(plainOut), .plainValid(plainValid), .plainReady(plainReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core stand-in: output reflects inputs seen LAT-1 edges earlier.
   function automatic logic [127:0] core_f(input logic [127:0] c, input logic [127:0] k);
      return (c == CT && k == K) ? PT : (c ^ k);
   endfunction

   logic [127:0] pipe [LAT-1];
   always @(posedge clk) begin
      pipe[0] <= core_f(cipherOut, keyOut);
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
   end
   assign plainIn = pipe[LAT-2];

   task automatic send_word(input logic [31:0] w, input logic k, output bit ok);
      int waited;
      inValid = 1'b1; inWord = w; inIsKey = k;
      #1;
      waited = 0;
      while (inReady !== 1'b1 && waited < 100) begin
         @(posedge clk); #2;
         waited++;
      end
      ok = (inReady === 1'b1);
      if (ok) begin
         @(posedge clk); #1;
      end
      inValid = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] blk, input logic k, output bit ok);
      bit one;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_word(blk[127-32*i -: 32], k, one);
         ok = ok & one;
      end
   endtask

   task automatic wait_plain(output int cyc);
      cyc = 0;
      while (plainValid !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic accept_plain();
      plainReady = 1'b1;
      @(posedge clk); #1;
      plainReady = 1'b0;
   endtask

   task automatic test_reset();
      inIsKey = 1'b0; #1;
      total_cnt++; if (keyOut !== '0) $display("FAIL reset_key got %h exp 0", keyOut); else pass_cnt++;
      total_cnt++; if (cipherOut !== '0) $display("FAIL reset_cipher got %h exp 0", cipherOut); else pass_cnt++;
      total_cnt++; if (plainOut !== '0) $display("FAIL reset_plain got %h exp 0", plainOut); else pass_cnt++;
      total_cnt++; if (plainValid !== 1'b0) $display("FAIL reset_pvalid got %b exp 0", plainValid); else pass_cnt++;
      total_cnt++; if (inReady !== 1'b0) $display("FAIL reset_ready_data got %b exp 0", inReady); else pass_cnt++;
      inIsKey = 1'b1; #1;
      total_cnt++; if (inReady !== 1'b1) $display("FAIL reset_ready_key got %b exp 1", inReady); else pass_cnt++;
   endtask

   task automatic test_data_before_key();
      int hits;
      bit ok;
      hits = 0;
      inValid = 1'b1; inIsKey = 1'b0; inWord = CT[127:96];
      for (int i = 0; i < 5; i++) begin
         #1; if (inReady !== 1'b0) hits++;
         @(posedge clk); #1;
      end
      total_cnt++; if (hits != 0) $display("FAIL nokey_refuse got %0d ready cycles exp 0", hits); else pass_cnt++;
      send_block(K, 1'b1, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL key_load got %b exp 1", ok); else pass_cnt++;
      total_cnt++; if (keyOut !== K) $display("FAIL key_value got %h exp %h", keyOut, K); else pass_cnt++;
      inIsKey = 1'b0; #1;
      total_cnt++; if (inReady !== 1'b1) $display("FAIL data_ready_after_key got %b exp 1", inReady); else pass_cnt++;
   endtask

   task automatic test_basic();
      bit ok;
      int cyc;
      send_block(CT, 1'b0, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL basic_load got %b exp 1", ok); else pass_cnt++;
      total_cnt++; if (cipherOut !== CT) $display("FAIL basic_cipher got %h exp %h", cipherOut, CT); else pass_cnt++;
      wait_plain(cyc);
      total_cnt++; if (cyc != LAT) $display("FAIL basic_latency got %0d exp %0d", cyc, LAT); else pass_cnt++;
      total_cnt++; if (plainOut !== PT) $display("FAIL basic_plain got %h exp %h", plainOut, PT); else pass_cnt++;
   endtask

   task automatic test_hold_stall();
      int bad;
      bad = 0;
      plainReady = 1'b0; inValid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         inIsKey = i[0]; #1;
         if (plainValid !== 1'b1 || plainOut !== PT || cipherOut !== CT ||
             keyOut !== K || inReady !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      total_cnt++; if (bad != 0) $display("FAIL hold_stable got %0d bad cycles exp 0", bad); else pass_cnt++;
      plainReady = 1'b1; inIsKey = 1'b1; #1;
      total_cnt++; if (inReady !== 1'b0) $display("FAIL hold_no_comb_ready got %b exp 0", inReady); else pass_cnt++;
      @(posedge clk); #1;
      plainReady = 1'b0;
      total_cnt++; if (plainValid !== 1'b0) $display("FAIL hold_release_pvalid got %b exp 0", plainValid); else pass_cnt++;
      total_cnt++; if (inReady !== 1'b1) $display("FAIL hold_back_to_load got %b exp 1", inReady); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bit ok;
      int cyc;
      send_block(C2, 1'b0, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL b2b_load got %b exp 1", ok); else pass_cnt++;
      wait_plain(cyc);
      total_cnt++; if (cyc != LAT) $display("FAIL b2b_latency got %0d exp %0d", cyc, LAT); else pass_cnt++;
      total_cnt++; if (plainOut !== PT2) $display("FAIL b2b_plain got %h exp %h", plainOut, PT2); else pass_cnt++;
      total_cnt++; if (keyOut !== K) $display("FAIL b2b_key got %h exp %h", keyOut, K); else pass_cnt++;
      accept_plain();
   endtask

   task automatic test_key_blocked();
      bit ok, o1, o2, o3;
      int cyc;
      send_word(C2[127:96], 1'b0, o1);
      send_word(C2[95:64], 1'b0, o2);
      inIsKey = 1'b1; #1;
      total_cnt++; if (inReady !== 1'b0) $display("FAIL partial_key_refused got %b exp 0", inReady); else pass_cnt++;
      send_word(C2[63:32], 1'b0, o3);
      send_word(C2[31:0], 1'b0, ok);
      ok = ok & o1 & o2 & o3;
      total_cnt++; if (ok !== 1'b1) $display("FAIL partial_data_load got %b exp 1", ok); else pass_cnt++;
      wait_plain(cyc);
      total_cnt++; if (plainOut !== PT2) $display("FAIL partial_plain got %h exp %h", plainOut, PT2); else pass_cnt++;
      inIsKey = 1'b1; #1;
      total_cnt++; if (inReady !== 1'b0) $display("FAIL hold_key_refused got %b exp 0", inReady); else pass_cnt++;
      accept_plain();
      send_word(32'hffffffff, 1'b1, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL rekey_word0 got %b exp 1", ok); else pass_cnt++;
      inIsKey = 1'b0; #1;
      total_cnt++; if (inReady !== 1'b0) $display("FAIL rekey_data_refused got %b exp 0", inReady); else pass_cnt++;
      total_cnt++; if (keyOut !== {32'hffffffff, K[95:0]})
         $display("FAIL rekey_mixed got %h exp %h", keyOut, {32'hffffffff, K[95:0]}); else pass_cnt++;
      send_word(K[95:64], 1'b1, o1);
      send_word(K[63:32], 1'b1, o2);
      send_word(K[31:0], 1'b1, o3);
      inIsKey = 1'b0; #1;
      total_cnt++; if (inReady !== 1'b1) $display("FAIL rekey_done_ready got %b exp 1", inReady); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int cyc, hits;
      send_block(K, 1'b1, ok);
      send_block(CT, 1'b0, ok);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      total_cnt++; if (plainValid !== 1'b0 || keyOut !== '0 || cipherOut !== '0 || plainOut !== '0)
         $display("FAIL midreset_outputs got pv=%b key=%h ct=%h pt=%h exp all 0", plainValid, keyOut, cipherOut, plainOut);
      else pass_cnt++;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      hits = 0;
      inIsKey = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1; if (inReady !== 1'b0) hits++;
         @(posedge clk); #1;
      end
      total_cnt++; if (hits != 0) $display("FAIL midreset_key_lost got %0d ready cycles exp 0", hits); else pass_cnt++;
      send_block(K, 1'b1, ok);
      send_block(CT, 1'b0, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL midreset_reload got %b exp 1", ok); else pass_cnt++;
      wait_plain(cyc);
      total_cnt++; if (plainOut !== PT || cyc != LAT)
         $display("FAIL midreset_plain got %h/%0d exp %h/%0d", plainOut, cyc, PT, LAT); else pass_cnt++;
      accept_plain();
   endtask

   initial begin
      rst_n = 1'b0; inValid = 1'b0; inIsKey = 1'b0; inWord = '0; plainReady = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      test_data_before_key();
      test_basic();
      test_hold_stall();
      test_back_to_back();
      test_key_blocked();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
